// File: rtl/parking_gate_controller.sv
// Parking gate controller: debounced entry/exit lane sensors, one gate FSM per
// lane, vacancy check at entry, single-cycle pass pulses for the counting block.

// Sensor conditioning: 2-FF synchronizer followed by a stability debouncer.
module pgc_sensor_filter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // Two-stage synchronizer for the asynchronous field input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Adopt the synchronized value only after it disagrees for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_2 != level) begin
            if (stable_cnt == CNT_LAST) begin
                level      <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end
endmodule

// State       | meaning
// E_IDLE      | entry lane empty, waiting for the approach loop
// E_CHECK     | one cycle: compare latched badge against the vacancy flags
// E_DENY      | no space for this class; hold denied until the car backs off
// E_OPEN      | gate open, waiting for the pass beam (timed)
// E_PASSING   | car under the gate; pulse on beam release
// E_CLOSE     | gate closed, wait for arm and beam to clear
// X_IDLE      | exit lane empty, waiting for the approach loop
// X_OPEN      | exit gate open, waiting for the pass beam (timed)
// X_PASSING   | car under the exit gate; pulse on beam release
// X_CLOSE     | exit gate closed, wait for arm and beam to clear
module parking_gate_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATE_TIMEOUT    = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic entry_arm,
    input  logic entry_beam,
    input  logic entry_is_uni,
    input  logic exit_arm,
    input  logic exit_beam,
    input  logic exit_is_uni,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic entry_denied
);
    localparam int TW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        E_IDLE, E_CHECK, E_DENY, E_OPEN, E_PASSING, E_CLOSE
    } entry_state_t;

    typedef enum logic [1:0] {
        X_IDLE, X_OPEN, X_PASSING, X_CLOSE
    } exit_state_t;

    entry_state_t  entry_state;
    exit_state_t   exit_state;
    logic          entry_arm_db;
    logic          entry_beam_db;
    logic          exit_arm_db;
    logic          exit_beam_db;
    logic          entry_uni_s1;
    logic          entry_uni_s2;
    logic          exit_uni_s1;
    logic          exit_uni_s2;
    logic          entry_uni;
    logic          exit_uni;
    logic [TW-1:0] entry_timer;
    logic [TW-1:0] exit_timer;

    pgc_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_arm (
        .clk(clk), .reset(reset), .raw(entry_arm), .level(entry_arm_db));
    pgc_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_beam (
        .clk(clk), .reset(reset), .raw(entry_beam), .level(entry_beam_db));
    pgc_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_arm (
        .clk(clk), .reset(reset), .raw(exit_arm), .level(exit_arm_db));
    pgc_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_beam (
        .clk(clk), .reset(reset), .raw(exit_beam), .level(exit_beam_db));

    // Badge bits are only synchronized; they are sampled once, when the arm is seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_uni_s1 <= 1'b0;
            entry_uni_s2 <= 1'b0;
            exit_uni_s1  <= 1'b0;
            exit_uni_s2  <= 1'b0;
        end else begin
            entry_uni_s1 <= entry_is_uni;
            entry_uni_s2 <= entry_uni_s1;
            exit_uni_s1  <= exit_is_uni;
            exit_uni_s2  <= exit_uni_s1;
        end
    end

    // Entry lane sequencing with vacancy check; outputs registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_state        <= E_IDLE;
            entry_uni          <= 1'b0;
            entry_timer        <= '0;
            entry_gate_open    <= 1'b0;
            entry_denied       <= 1'b0;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
        end else begin
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            case (entry_state)
                E_IDLE: begin
                    if (entry_arm_db) begin
                        entry_uni   <= entry_uni_s2;
                        entry_state <= E_CHECK;
                    end
                end
                E_CHECK: begin
                    if (entry_uni ? uni_is_vacated_space : is_vacated_space) begin
                        entry_state     <= E_OPEN;
                        entry_gate_open <= 1'b1;
                        entry_timer     <= '0;
                    end else begin
                        entry_state  <= E_DENY;
                        entry_denied <= 1'b1;
                    end
                end
                E_DENY: begin
                    if (!entry_arm_db) begin
                        entry_state  <= E_IDLE;
                        entry_denied <= 1'b0;
                    end
                end
                E_OPEN: begin
                    if (entry_beam_db) begin
                        entry_state <= E_PASSING;
                    end else if (entry_timer == TIMER_LAST) begin
                        entry_state     <= E_CLOSE;
                        entry_gate_open <= 1'b0;
                    end else begin
                        entry_timer <= entry_timer + 1'b1;
                    end
                end
                E_PASSING: begin
                    if (!entry_beam_db) begin
                        entry_state        <= E_CLOSE;
                        entry_gate_open    <= 1'b0;
                        car_entered        <= 1'b1;
                        is_uni_car_entered <= entry_uni;
                    end
                end
                E_CLOSE: begin
                    if (!entry_arm_db && !entry_beam_db) begin
                        entry_state <= E_IDLE;
                    end
                end
                default: begin
                    entry_state     <= E_IDLE;
                    entry_gate_open <= 1'b0;
                    entry_denied    <= 1'b0;
                end
            endcase
        end
    end

    // Exit lane sequencing: no vacancy check, arm opens the gate directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exit_state        <= X_IDLE;
            exit_uni          <= 1'b0;
            exit_timer        <= '0;
            exit_gate_open    <= 1'b0;
            car_exited        <= 1'b0;
            is_uni_car_exited <= 1'b0;
        end else begin
            car_exited        <= 1'b0;
            is_uni_car_exited <= 1'b0;
            case (exit_state)
                X_IDLE: begin
                    if (exit_arm_db) begin
                        exit_uni       <= exit_uni_s2;
                        exit_state     <= X_OPEN;
                        exit_gate_open <= 1'b1;
                        exit_timer     <= '0;
                    end
                end
                X_OPEN: begin
                    if (exit_beam_db) begin
                        exit_state <= X_PASSING;
                    end else if (exit_timer == TIMER_LAST) begin
                        exit_state     <= X_CLOSE;
                        exit_gate_open <= 1'b0;
                    end else begin
                        exit_timer <= exit_timer + 1'b1;
                    end
                end
                X_PASSING: begin
                    if (!exit_beam_db) begin
                        exit_state        <= X_CLOSE;
                        exit_gate_open    <= 1'b0;
                        car_exited        <= 1'b1;
                        is_uni_car_exited <= exit_uni;
                    end
                end
                X_CLOSE: begin
                    if (!exit_arm_db && !exit_beam_db) begin
                        exit_state <= X_IDLE;
                    end
                end
                default: begin
                    exit_state     <= X_IDLE;
                    exit_gate_open <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: stimulus queues expected output
// events (cycle + value), a negedge monitor matches every observed event.
module tb_parking_gate_controller;
    localparam int D  = 4;
    localparam int TO = 16;

    localparam int K_ENT   = 0;
    localparam int K_EXT   = 1;
    localparam int K_EGATE = 2;
    localparam int K_XGATE = 3;
    localparam int K_DENY  = 4;
    localparam int K_QENT  = 5;
    localparam int K_QEXT  = 6;

    typedef struct {
        int   kind;
        int   cyc;
        logic val;
    } ev_t;

    logic clk;
    logic reset;
    logic entry_arm, entry_beam, entry_is_uni;
    logic exit_arm, exit_beam, exit_is_uni;
    logic uni_is_vacated_space, is_vacated_space;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic entry_gate_open, exit_gate_open, entry_denied;

    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    ev_t  exp_q[$];
    logic prev_egate = 1'b0;
    logic prev_xgate = 1'b0;
    logic prev_deny  = 1'b0;

    parking_gate_controller #(.DEBOUNCE_CYCLES(D), .GATE_TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .entry_arm(entry_arm),
        .entry_beam(entry_beam),
        .entry_is_uni(entry_is_uni),
        .exit_arm(exit_arm),
        .exit_beam(exit_beam),
        .exit_is_uni(exit_is_uni),
        .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space(is_vacated_space),
        .car_entered(car_entered),
        .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited),
        .is_uni_car_exited(is_uni_car_exited),
        .entry_gate_open(entry_gate_open),
        .exit_gate_open(exit_gate_open),
        .entry_denied(entry_denied)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_ENT:   return "car_entered";
            K_EXT:   return "car_exited";
            K_EGATE: return "entry_gate_open";
            K_XGATE: return "exit_gate_open";
            K_DENY:  return "entry_denied";
            K_QENT:  return "is_uni_car_entered_without_pulse";
            default: return "is_uni_car_exited_without_pulse";
        endcase
    endfunction

    task automatic push(input int kind, input int at, input logic val);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int kind, input logic val);
        int idx = -1;
        total_cnt++;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].kind == kind) idx = i;
        if (idx < 0) begin
            $display("FAIL %s: unexpected event at cycle %0d value %0b, none required", kname(kind), cyc, val);
        end else begin
            if (exp_q[idx].cyc == cyc && exp_q[idx].val == val)
                pass_cnt++;
            else
                $display("FAIL %s: got cycle %0d value %0b, required cycle %0d value %0b",
                         kname(kind), cyc, val, exp_q[idx].cyc, exp_q[idx].val);
            exp_q.delete(idx);
        end
    endtask

    task automatic check_eq(input string name, input logic act, input logic req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %b, required %b", name, act, req);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_car_entered"}, car_entered, 1'b0);
        check_eq({tag, "_is_uni_car_entered"}, is_uni_car_entered, 1'b0);
        check_eq({tag, "_car_exited"}, car_exited, 1'b0);
        check_eq({tag, "_is_uni_car_exited"}, is_uni_car_exited, 1'b0);
        check_eq({tag, "_entry_gate_open"}, entry_gate_open, 1'b0);
        check_eq({tag, "_exit_gate_open"}, exit_gate_open, 1'b0);
        check_eq({tag, "_entry_denied"}, entry_denied, 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse and every level edge on the outputs is an event to match
    always @(negedge clk) begin
        if (car_entered) match_ev(K_ENT, is_uni_car_entered);
        if (car_exited) match_ev(K_EXT, is_uni_car_exited);
        if (!car_entered && is_uni_car_entered) match_ev(K_QENT, 1'b1);
        if (!car_exited && is_uni_car_exited) match_ev(K_QEXT, 1'b1);
        if (entry_gate_open !== prev_egate) match_ev(K_EGATE, entry_gate_open);
        if (exit_gate_open !== prev_xgate) match_ev(K_XGATE, exit_gate_open);
        if (entry_denied !== prev_deny) match_ev(K_DENY, entry_denied);
        prev_egate = entry_gate_open;
        prev_xgate = exit_gate_open;
        prev_deny  = entry_denied;
    end

    initial begin
        int c;
        reset = 1'b1;
        entry_arm = 1'b0; entry_beam = 1'b0; entry_is_uni = 1'b0;
        exit_arm = 1'b0; exit_beam = 1'b0; exit_is_uni = 1'b0;
        uni_is_vacated_space = 1'b0; is_vacated_space = 1'b0;

        tick(1);
        check_all_zero("reset");
        tick(3);
        reset = 1'b0;
        tick(3);

        // Uni entry with uni space free: open, 20-cycle beam, one pulse with uni=1
        c = cyc;
        entry_is_uni = 1'b1; uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
        entry_arm = 1'b1;
        push(K_EGATE, c + 3 + D + 1, 1'b1);
        tick(8);
        entry_beam = 1'b1;
        tick(20);
        entry_beam = 1'b0; entry_arm = 1'b0;
        push(K_ENT, c + 28 + 2 + D + 1, 1'b1);
        push(K_EGATE, c + 28 + 2 + D + 1, 1'b0);
        tick(30);

        // Non-uni entry, only uni space free: denied, beam in DENY ignored, arm drop clears
        c = cyc;
        entry_is_uni = 1'b0; is_vacated_space = 1'b0; uni_is_vacated_space = 1'b1;
        entry_arm = 1'b1;
        push(K_DENY, c + 8, 1'b1);
        tick(9);
        entry_beam = 1'b1;
        tick(10);
        entry_beam = 1'b0;
        tick(1);
        entry_arm = 1'b0;
        push(K_DENY, c + 20 + 2 + D + 1, 1'b0);
        tick(20);

        // Timeout: gate open exactly TO cycles, no pulse; arm held past close
        c = cyc;
        is_vacated_space = 1'b1; uni_is_vacated_space = 1'b0;
        entry_arm = 1'b1;
        push(K_EGATE, c + 8, 1'b1);
        push(K_EGATE, c + 8 + TO, 1'b0);
        tick(30);
        entry_arm = 1'b0;
        tick(20);

        // Two-cycle beam glitches while open: no PASSING, timeout still closes the gate
        c = cyc;
        entry_arm = 1'b1;
        push(K_EGATE, c + 8, 1'b1);
        push(K_EGATE, c + 8 + TO, 1'b0);
        tick(9);
        entry_beam = 1'b1;
        tick(2);
        entry_beam = 1'b0;
        tick(3);
        entry_beam = 1'b1;
        tick(2);
        entry_beam = 1'b0;
        tick(14);
        entry_arm = 1'b0;
        tick(20);

        // Simultaneous uni entry and non-uni exit, both beams fall together
        c = cyc;
        entry_is_uni = 1'b1; uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
        exit_is_uni = 1'b0;
        entry_arm = 1'b1; exit_arm = 1'b1;
        push(K_EGATE, c + 8, 1'b1);
        push(K_XGATE, c + 7, 1'b1);
        tick(9);
        entry_beam = 1'b1; exit_beam = 1'b1;
        tick(20);
        entry_beam = 1'b0; exit_beam = 1'b0; entry_arm = 1'b0; exit_arm = 1'b0;
        push(K_ENT, c + 36, 1'b1);
        push(K_EXT, c + 36, 1'b0);
        push(K_EGATE, c + 36, 1'b0);
        push(K_XGATE, c + 36, 1'b0);
        tick(30);

        // Reset while PASSING: outputs drop at once, later beam fall gives no pulse
        c = cyc;
        entry_is_uni = 1'b1; uni_is_vacated_space = 1'b1;
        entry_arm = 1'b1;
        push(K_EGATE, c + 8, 1'b1);
        tick(9);
        entry_beam = 1'b1;
        tick(3);
        entry_arm = 1'b0;
        tick(8);
        #2;
        reset = 1'b1;
        push(K_EGATE, c + 21, 1'b0);
        #1;
        check_all_zero("async_reset");
        tick(3);
        reset = 1'b0;
        tick(12);
        entry_beam = 1'b0;
        tick(25);

        #1;
        foreach (exp_q[i]) begin
            total_cnt++;
            $display("FAIL %s: event never seen, required at cycle %0d value %0b",
                     kname(exp_q[i].kind), exp_q[i].cyc, exp_q[i].val);
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
